// File: rtl/shift_rows_stream.sv
// Streaming Rijndael ShiftRows / InvShiftRows over NB 32-bit columns with a 2-entry elastic output buffer.
// Optional macro SHIFTROW_BYPASS_EN adds in_byp, which passes the state through unpermuted.
module shift_rows_stream #(
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [32*NB-1:0] sb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_inv,
  output logic [32*NB-1:0] sr
`ifdef SHIFTROW_BYPASS_EN
  ,
  input  logic            in_byp
`endif
);

  localparam int W = 32 * NB;

  // Handshake: a beat moves on a side only in a cycle where its valid and ready are both high.
  // in_ready and out_valid are decoded from the registered buffer state only, so out_ready never
  // reaches in_ready combinationally; both are forced low while rst is high.

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_inv_q, main_inv_d;
  logic         skid_inv_q, skid_inv_d;

  logic [W-1:0] fwd_w;
  logic [W-1:0] inv_w;
  logic [W-1:0] perm_w;
  logic         in_xfer;
  logic         out_xfer;

  // Pure wiring: every source column index is resolved during elaboration.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int SHIFT = (NB == 8 && r >= 2) ? r + 1 : r;
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SRC_FWD = (c + SHIFT) % NB;
      localparam int SRC_INV = (c + NB - SHIFT) % NB;
      assign fwd_w[W-1-8*(4*c+r) -: 8] = sb[W-1-8*(4*SRC_FWD+r) -: 8];
      assign inv_w[W-1-8*(4*c+r) -: 8] = sb[W-1-8*(4*SRC_INV+r) -: 8];
    end
  end

  always_comb begin
    perm_w = in_inv ? inv_w : fwd_w;
`ifdef SHIFTROW_BYPASS_EN
    if (in_byp) begin
      perm_w = sb;
    end
`endif
  end

  assign out_valid = (state_q != S_EMPTY) && !rst;
  assign in_ready  = (state_q != S_TWO) && !rst;
  assign sr        = main_q;
  assign out_inv   = main_inv_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_inv_d = main_inv_q;
    skid_d     = skid_q;
    skid_inv_d = skid_inv_q;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          main_d     = perm_w;
          main_inv_d = in_inv;
          state_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d     = perm_w;
          main_inv_d = in_inv;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end else if (in_xfer) begin
          // Main is stalled downstream; park the new beat behind it.
          skid_d     = perm_w;
          skid_inv_d = in_inv;
          state_d    = S_TWO;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          main_d     = skid_q;
          main_inv_d = skid_inv_q;
          state_d    = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      main_inv_q <= 1'b0;
      skid_q     <= '0;
      skid_inv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_inv_q <= main_inv_d;
      skid_q     <= skid_d;
      skid_inv_q <= skid_inv_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4 scoreboarded stream plus NB=8 / NB=6 pattern checks.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_inv4;
  logic [127:0] sb4, sr4;
  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
  logic [255:0] sb8, sr8;
  logic         in_valid6, in_ready6, in_inv6, out_valid6, out_ready6, out_inv6;
  logic [191:0] sb6, sr6;
  logic         byp_now = 1'b0;
`ifdef SHIFTROW_BYPASS_EN
  logic         byp4, byp8, byp6;
`endif

  logic [128:0] exp_q[$];

  shift_rows_stream #(.NB(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4),
    .sb(sb4), .out_valid(out_valid4), .out_ready(out_ready4), .out_inv(out_inv4), .sr(sr4)
`ifdef SHIFTROW_BYPASS_EN
    , .in_byp(byp4)
`endif
  );

  shift_rows_stream #(.NB(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
    .sb(sb8), .out_valid(out_valid8), .out_ready(out_ready8), .out_inv(out_inv8), .sr(sr8)
`ifdef SHIFTROW_BYPASS_EN
    , .in_byp(byp8)
`endif
  );

  shift_rows_stream #(.NB(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .in_inv(in_inv6),
    .sb(sb6), .out_valid(out_valid6), .out_ready(out_ready6), .out_inv(out_inv6), .sr(sr6)
`ifdef SHIFTROW_BYPASS_EN
    , .in_byp(byp6)
`endif
  );

  // Reference model from the byte map: byte (r,c) at [W-1-8*(4c+r) -: 8], data right-aligned.
  function automatic logic [255:0] model(input logic [255:0] d, input logic inv,
                                         input logic byp, input int nb);
    int sh[4];
    int w;
    int src;
    logic [255:0] res;
    res = '0;
    w = 32 * nb;
    if (nb == 8) begin
      sh[0] = 0; sh[1] = 1; sh[2] = 3; sh[3] = 4;
    end else begin
      sh[0] = 0; sh[1] = 1; sh[2] = 2; sh[3] = 3;
    end
    if (byp) return d;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) begin
        if (inv) src = (c - sh[r] + nb) % nb;
        else     src = (c + sh[r]) % nb;
        res[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Called at posedge+1; offers one beat for one cycle and pushes the expectation if accepted.
  task automatic step_offer4(input logic [127:0] d, input logic inv, output logic acc);
    logic [255:0] m;
    in_valid4 = 1'b1;
    sb4       = d;
    in_inv4   = inv;
`ifdef SHIFTROW_BYPASS_EN
    byp4      = byp_now;
`endif
    @(negedge clk);
    acc = in_ready4;
    @(posedge clk);
    if (acc) begin
      m = model(256'(d), inv, byp_now, 4);
      exp_q.push_back({inv, m[127:0]});
    end
    #1;
  endtask

  task automatic send4(input logic [127:0] d, input logic inv);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step_offer4(d, inv, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 257'(acc), 257'd1);
  endtask

  task automatic idle4(input int n);
    in_valid4 = 1'b0;
    for (int i = 0; i < n; i++) begin
      sb4     = {$urandom, $urandom, $urandom, $urandom};
      in_inv4 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [128:0] e;
    if (out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 257'(out_valid4), 257'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat4", 257'({out_inv4, sr4}), 257'(e));
      end
    end
  end

  initial begin
    logic acc;
    logic [127:0] a, b, c, rnd;
    logic [255:0] pat8, r8, m;
    logic [191:0] pat6, r6;

    in_valid4 = 0; in_inv4 = 0; sb4 = '0; out_ready4 = 0;
    in_valid8 = 0; in_inv8 = 0; sb8 = '0; out_ready8 = 0;
    in_valid6 = 0; in_inv6 = 0; sb6 = '0; out_ready6 = 0;
`ifdef SHIFTROW_BYPASS_EN
    byp4 = 0; byp8 = 0; byp6 = 0;
`endif

    // Reset values, then in_ready rises in the first cycle after rst falls.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 257'(in_ready4), 257'd0);
    chk("rst_out_valid", 257'(out_valid4), 257'd0);
    chk("rst_sr", 257'(sr4), 257'd0);
    chk("rst_out_inv", 257'(out_inv4), 257'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 257'(in_ready4), 257'd1);
    chk("post_rst_out_valid", 257'(out_valid4), 257'd0);
    @(posedge clk); #1;

    // Known forward vector, latency 1.
    out_ready4 = 1'b1;
    send4(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("t1_latency", 257'(out_valid4), 257'd1);
    chk("t1_sr", 257'(sr4), 257'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    chk("t1_inv", 257'(out_inv4), 257'd0);
    @(posedge clk); #1;

    // Known inverse vector, then alternating back-to-back beats.
    send4(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("t2_sr", 257'(sr4), 257'(128'hd42711aee0bf98f1b8b45de51e415230));
    chk("t2_inv", 257'(out_inv4), 257'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step_offer4(rnd, 1'(i % 2), acc);
      chk("t2_throughput", 257'(acc), 257'd1);
    end
    idle4(3);

    // NB=8 and NB=6 with byte k = k.
    pat8 = '0;
    pat6 = '0;
    for (int k = 0; k < 32; k++) pat8[255-8*k -: 8] = 8'(k);
    for (int k = 0; k < 24; k++) pat6[191-8*k -: 8] = 8'(k);
    out_ready8 = 1'b1; out_ready6 = 1'b1;
    in_valid8 = 1'b1; sb8 = pat8; in_inv8 = 1'b0;
    in_valid6 = 1'b1; sb6 = pat6; in_inv6 = 1'b0;
    @(negedge clk);
    chk("t3_nb8_ready", 257'(in_ready8), 257'd1);
    chk("t3_nb6_ready", 257'(in_ready6), 257'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_valid6 = 1'b0;
    @(negedge clk);
    chk("t3_nb8_valid", 257'(out_valid8), 257'd1);
    chk("t3_nb8_col0", 257'(sr8[255:224]), 257'(32'h00050e13));
    m = model(pat8, 1'b0, 1'b0, 8);
    chk("t3_nb8_full", 257'(sr8), 257'(m));
    chk("t3_nb6_valid", 257'(out_valid6), 257'd1);
    chk("t3_nb6_col0", 257'(sr6[191:160]), 257'(32'h00050a0f));
    m = model(256'(pat6), 1'b0, 1'b0, 6);
    chk("t3_nb6_full", 257'(sr6), 257'(m[191:0]));
    r8 = sr8;
    r6 = sr6;
    @(posedge clk); #1;
    in_valid8 = 1'b1; sb8 = r8; in_inv8 = 1'b1;
    in_valid6 = 1'b1; sb6 = r6; in_inv6 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_valid6 = 1'b0;
    @(negedge clk);
    chk("t3_nb8_roundtrip", 257'(sr8), 257'(pat8));
    chk("t3_nb8_inv", 257'(out_inv8), 257'd1);
    chk("t3_nb6_roundtrip", 257'(sr6), 257'(pat6));
    @(posedge clk); #1;

    // Backpressure: A and B fill the buffer, C is held, output stays stable.
    out_ready4 = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    step_offer4(a, 1'b0, acc);
    chk("t4_acc_a", 257'(acc), 257'd1);
    step_offer4(b, 1'b1, acc);
    chk("t4_acc_b", 257'(acc), 257'd1);
    m = model(256'(a), 1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      step_offer4(c, 1'b0, acc);
      chk("t4_c_held", 257'(acc), 257'd0);
      chk("t4_stable", 257'({out_valid4, out_inv4, sr4}), 257'({1'b1, 1'b0, m[127:0]}));
    end
    out_ready4 = 1'b1;
    send4(c, 1'b0);
    idle4(4);

    // Reset with two beats stored: both are discarded.
    out_ready4 = 1'b0;
    step_offer4({$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
    chk("t5_acc_1", 257'(acc), 257'd1);
    step_offer4({$urandom, $urandom, $urandom, $urandom}, 1'b1, acc);
    chk("t5_acc_2", 257'(acc), 257'd1);
    rst = 1'b1;
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_valid", 257'(out_valid4), 257'd0);
    chk("t5_rst_ready", 257'(in_ready4), 257'd0);
    @(posedge clk); #1;
    chk("t5_rst_sr", 257'({out_inv4, sr4}), 257'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 257'(in_ready4), 257'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_stale", 257'(out_valid4), 257'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    send4(rnd, 1'b1);
    idle4(3);

`ifdef SHIFTROW_BYPASS_EN
    byp_now = 1'b1;
    send4(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("t6_byp_sr", 257'(sr4), 257'(128'h000102030405060708090a0b0c0d0e0f));
    chk("t6_byp_inv", 257'(out_inv4), 257'd1);
    @(posedge clk); #1;
    byp_now = 1'b0;
    byp4 = 1'b0;
    idle4(3);
`endif

    idle4(5);
    chk("drain_empty", 257'(exp_q.size()), 257'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
